// File: rtl/gate_pipe.sv
// gate_pipe: registered eight-function bitwise gate with a 2-entry output skid buffer.
// Ports: clk/rst (sync, active-high), in_valid/in_ready/op/A/B upstream;
//        out_valid/out_ready/X/x_any/x_all/x_par downstream; txn_cnt counts retires.
module gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic             x_any,
    output logic             x_all,
    output logic             x_par,
    output logic [CNT_W-1:0] txn_cnt
);

    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] tail_x;
    logic [WIDTH-1:0] head_nxt;
    logic             push;
    logic             pop;
    logic             load_new;
    logic             load_tail;

    always_comb begin
        res = A;
        case (op)
            3'b000:  res = A & B;
            3'b001:  res = A | B;
            3'b010:  res = A ^ B;
            3'b011:  res = ~(A & B);
            3'b100:  res = ~(A | B);
            3'b101:  res = ~(A ^ B);
            3'b110:  res = ~A;
            default: res = A;
        endcase
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};

    // The head register is the visible output; it takes the new result
    // when it is (or is about to become) the only entry, otherwise the
    // second entry moves up when the head retires from a full buffer.
    assign load_new  = push & ((occ == 2'd0) | ((occ == 2'd1) & pop));
    assign load_tail = pop & (occ == 2'd2);

    always_comb begin
        head_nxt = X;
        if (load_new) begin
            head_nxt = res;
        end else if (load_tail) begin
            head_nxt = tail_x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            X         <= '0;
            x_any     <= 1'b0;
            x_all     <= 1'b0;
            x_par     <= 1'b0;
            tail_x    <= '0;
            txn_cnt   <= '0;
        end else begin
            occ       <= occ_nxt;
            in_ready  <= (occ_nxt != 2'd2);
            out_valid <= (occ_nxt != 2'd0);
            txn_cnt   <= txn_cnt + CNT_W'(pop);
            // Only meaningful when the push lands behind an occupied head.
            if (push) begin
                tail_x <= res;
            end
            X     <= head_nxt;
            x_any <= |head_nxt;
            x_all <= &head_nxt;
            x_par <= ^head_nxt;
        end
    end

endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: vector tables, directed corner sequences and a random run
// compared every cycle against a queue-based model of gate_pipe.
module tb_gate_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'd0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] X;
    logic       x_any;
    logic       x_all;
    logic       x_par;
    logic [3:0] txn_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    int         mcnt = 0;
    int         hs = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] x;
        logic       any;
        logic       all;
        logic       par;
    } vec_t;

    vec_t tt[11];

    gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .X(X), .x_any(x_any), .x_all(x_all), .x_par(x_par),
        .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gate_ref(logic [2:0] f, logic [7:0] a, logic [7:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [7:0] hx;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("txn_cnt", 32'(txn_cnt), 32'(mcnt % 16));
        if (mq.size() != 0) begin
            hx = mq[0];
            chk("X", 32'(X), 32'(hx));
            chk("x_any", 32'(x_any), 32'(hx != 8'h00));
            chk("x_all", 32'(x_all), 32'(hx == 8'hFF));
            chk("x_par", 32'(x_par), 32'($countones(hx) % 2));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then
    // compare everything at the following falling edge.
    task automatic step(logic r, logic iv, logic [2:0] f, logic [7:0] a,
                        logic [7:0] b, logic ordy);
        logic acc;
        logic ret;
        rst = r;
        in_valid = iv;
        op = f;
        A = a;
        B = b;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcnt = 0;
            hs = 0;
        end else begin
            acc = iv && (mq.size() < 2);
            ret = (mq.size() != 0) && ordy;
            if (ret) begin
                void'(mq.pop_front());
                mcnt++;
                hs++;
            end
            if (acc) mq.push_back(gate_ref(f, a, b));
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(logic ordy);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, ordy);
    endtask

    initial begin
        tt[0]  = '{3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b1, 1'b0, 1'b0};
        tt[1]  = '{3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b1, 1'b0, 1'b0};
        tt[2]  = '{3'd2, 8'hF0, 8'hCC, 8'h3C, 1'b1, 1'b0, 1'b0};
        tt[3]  = '{3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b1, 1'b0, 1'b0};
        tt[4]  = '{3'd4, 8'hF0, 8'hCC, 8'h03, 1'b1, 1'b0, 1'b0};
        tt[5]  = '{3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b1, 1'b0, 1'b0};
        tt[6]  = '{3'd6, 8'hF0, 8'hCC, 8'h0F, 1'b1, 1'b0, 1'b0};
        tt[7]  = '{3'd7, 8'hF0, 8'hCC, 8'hF0, 1'b1, 1'b0, 1'b0};
        tt[8]  = '{3'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tt[9]  = '{3'd1, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
        tt[10] = '{3'd7, 8'h01, 8'h5A, 8'h01, 1'b1, 1'b0, 1'b1};

        // Reset state
        step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
        chk("rst_X", 32'(X), 32'd0);
        chk("rst_flags", {29'd0, x_any, x_all, x_par}, 32'd0);

        // Truth table and flag vectors, one accept per cycle
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, tt[i].op, tt[i].a, tt[i].b, 1'b1);
            chk("tt_valid", 32'(out_valid), 32'd1);
            chk("tt_X", 32'(X), 32'(tt[i].x));
            chk("tt_any", 32'(x_any), 32'(tt[i].any));
            chk("tt_all", 32'(x_all), 32'(tt[i].all));
            chk("tt_par", 32'(x_par), 32'(tt[i].par));
            if (i == 7) begin
                idle(1'b1);
                chk("tt_txn_cnt", 32'(txn_cnt), 32'd8);
            end
        end
        idle(1'b1);

        // Backpressure: three offers, two fit
        step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd7, 8'h11, 8'h00, 1'b0);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 3'd7, 8'h22, 8'h00, 1'b0);
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 3'd7, 8'h33, 8'h00, 1'b0);
        chk("bp_hold_X", 32'(X), 32'h11);
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 3'd7, 8'h33, 8'h00, 1'b1);
        chk("bp_drain1", 32'(X), 32'h22);
        step(1'b0, 1'b1, 3'd7, 8'h33, 8'h00, 1'b1);
        chk("bp_drain2", 32'(X), 32'h33);
        idle(1'b1);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_cnt", 32'(txn_cnt), 32'd3);

        // Simultaneous push/pop at occupancy 1
        step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 3'd7, 8'(i + 1), 8'h00, 1'b1);
            chk("pp_rdy", 32'(in_ready), 32'd1);
            chk("pp_X", 32'(X), 32'(i + 1));
        end
        chk("pp_cnt", 32'(txn_cnt), 32'd10);

        // Reset while full
        step(1'b0, 1'b1, 3'd0, 8'hAA, 8'h55, 1'b0);
        chk("mid_full", 32'(in_ready), 32'd0);
        step(1'b1, 1'b1, 3'd1, 8'h0F, 8'h00, 1'b1);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_rdy", 32'(in_ready), 32'd1);
        chk("mid_cnt", 32'(txn_cnt), 32'd0);
        chk("mid_X", 32'(X), 32'd0);
        step(1'b0, 1'b1, 3'd0, 8'hF0, 8'hCC, 1'b1);
        chk("mid_new", 32'(X), 32'hC0);
        idle(1'b1);

        // Counter wrap at 4 bits
        step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 40 && hs < 17; i++) begin
            step(1'b0, 1'b1, 3'd2, 8'(i), 8'h3C, 1'b1);
            if (hs == 15) chk("wrap15", 32'(txn_cnt), 32'd15);
            if (hs == 16) chk("wrap16", 32'(txn_cnt), 32'd0);
            if (hs == 17) chk("wrap17", 32'(txn_cnt), 32'd1);
        end
        chk("wrap_reached", 32'(hs >= 17), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_pipe.md
Name: gate_pipe

Overview:
- Parametrised, registered successor to the single-bit two-input OR gate.
- Applies one of eight selectable bitwise gate functions to two WIDTH-bit operands.
- Each result is buffered with reduction flags in a 2-entry output skid buffer, under a valid/ready handshake.
- Sits between a stimulus source and any consumer; it is the standard gate primitive for pipelined datapaths and self-checking benches.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept; registered.
- op  input  3  function select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 PASS A.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (ignored for op 110/111).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- X  output  WIDTH  result.
- x_any  output  1  reduction OR of X.
- x_all  output  1  reduction AND of X.
- x_par  output  1  reduction XOR of X (odd parity).
- txn_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset: rst sampled high at a rising edge empties the buffer and sets:
  - out_valid=0, in_ready=1, txn_cnt=0;
  - X, x_any, x_all, x_par all 0.
  - Reset overrides any handshake in the same cycle; in-flight entries are discarded, not counted.
- Accept: input is accepted when in_valid & in_ready at the edge. A, B and op are sampled only then. The result and flags are computed from the sampled values and stored as one entry.
- Latency: accept at edge k into an empty buffer gives out_valid=1 with the matching X and flags in the cycle after edge k. This is one-cycle latency, with no combinational path from inputs to outputs.
- Output handshake: an entry is retired when out_valid & out_ready at the edge.
  - While out_valid=1 and out_ready=0, X, the flags and out_valid hold stable.
  - out_valid never drops without a handshake, except on reset.
- Buffer: 2 entries, FIFO order. Occupancy 0/1/2.
  - in_ready = (occupancy < 2), computed from the registered next-state occupancy.
  - Full (2): in_ready=0; in_valid is ignored.
  - Empty (0): out_valid=0; X and flags hold their last values (don't-care for checking).
  - Simultaneous accept and retire at occupancy 1: occupancy stays 1; the head advances to the new entry; out_valid stays 1.
  - Simultaneous accept and retire at occupancy 0: impossible, since out_valid=0.
  - Full with a retire: occupancy goes to 1; in_ready rises the next cycle.
- Throughput: 1 transaction/cycle sustained while out_ready=1.
- Flags: computed from the stored X of the same entry, never from live inputs.
- txn_cnt: increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0 with no flag.
- Illegal states: none; all op codes are defined.

Test Plan:
- Truth table, WIDTH=8, out_ready=1: A=8'hF0, B=8'hCC, op 0..7 on consecutive cycles. Required X sequence is C0, FC, 3C, 3F, 03, C3, 0F, F0, one cycle after each accept. txn_cnt ends at 8.
- Flags: op=001 with A=B=0 gives X=00, x_any=0, x_all=0, x_par=0. Op=001 with A=FF gives x_all=1, x_any=1, x_par=0. Op=111 with A=01 gives x_par=1.
- Backpressure: out_ready=0 while in_valid=1 with 3 distinct inputs. in_ready falls after the 2nd accept and the 3rd is held off. X stays equal to the 1st result. Then out_ready=1: results drain in order 1,2,3 with no loss or duplication.
- Simultaneous push/pop: occupancy 1, in_valid=1, out_ready=1 for 10 cycles with incrementing A. 10 results come out in order, in_ready stays 1 throughout, txn_cnt=+10.
- Reset mid-operation: buffer full, assert rst for 1 cycle. Next cycle out_valid=0, in_ready=1, txn_cnt=0, X=0. A new accept then produces a correct result 1 cycle later.
- Wrap: CNT_W=4, 17 handshakes. txn_cnt reads 15 after the 15th handshake, 0 after the 16th, and 1 after the 17th.
